// File: rtl/apb_master_bridge.sv
// Upstream single-beat request to AMBA APB master bridge.
// It decodes the slave from the address and aborts on a wait-state timeout.
module apb_master_bridge #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned NO_SLAVES       = 1,
    parameter int unsigned SLAVE_SPAN_BITS = 12,
    parameter int unsigned TIMEOUT_CYCLES  = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [NO_SLAVES-1:0]  PSELx,
    output logic                  PENABLE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      wait_cnt;
    logic [ADDR_WIDTH-1:0] slave_idx_c;
    logic                  hit_c;
    logic [NO_SLAVES-1:0]  sel_c;
    logic                  timeout_c;

    // Address decode to a one-hot slave select.
    always_comb begin
        slave_idx_c = req_addr >> SLAVE_SPAN_BITS;
        hit_c       = (slave_idx_c < ADDR_WIDTH'(NO_SLAVES));
        sel_c       = '0;
        for (int unsigned i = 0; i < NO_SLAVES; i++) begin
            sel_c[i] = (slave_idx_c == ADDR_WIDTH'(i));
        end
    end

    // The current low-PREADY cycle is the last one allowed when the count
    // of earlier wait states has reached TIMEOUT_CYCLES-1.
    assign timeout_c = TO_EN && (wait_cnt == CNT_W'(TO_LAST));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            PSELx     <= '0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        PWRITE <= req_write;
                        PADDR  <= req_addr;
                        PWDATA <= req_wdata;
                        if (hit_c) begin
                            state     <= SETUP;
                            PSELx     <= sel_c;
                            req_ready <= 1'b0;
                            wait_cnt  <= '0;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: begin
                    if (PREADY) begin
                        state     <= IDLE;
                        PSELx     <= '0;
                        PENABLE   <= 1'b0;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_err   <= PSLVERR;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                    end else if (timeout_c) begin
                        state     <= IDLE;
                        PSELx     <= '0;
                        PENABLE   <= 1'b0;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    PSELx     <= '0;
                    PENABLE   <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: a vector table replayed through one
// transaction task against a configurable-wait slave, plus a mid-transfer reset.
`timescale 1ns/1ps
module tb_apb_master_bridge;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [3:0]  PSELx;
    logic        PENABLE;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA = 32'hBAD0_BAD0;
    logic        PREADY = 1'b1;
    logic        PSLVERR = 1'b1;

    int          n_chk = 0;
    int          n_fail = 0;

    // Slave behaviour for the current transaction, set by the driving task.
    int          slave_waits = 0;
    logic [31:0] slave_rdata = '0;
    logic        slave_err = 1'b0;
    int          wcnt = 0;

    apb_master_bridge #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .NO_SLAVES      (4),
        .SLAVE_SPAN_BITS(12),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .PSELx    (PSELx),
        .PENABLE  (PENABLE),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Slave model: inserts slave_waits wait states, drives junk outside the data beat.
    always @(negedge PCLK) begin
        if (PSELx != 4'b0 && PENABLE) begin
            if (wcnt < slave_waits) begin
                PREADY  = 1'b0;
                wcnt    = wcnt + 1;
                PRDATA  = 32'hBAD0_BAD0;
                PSLVERR = 1'b1;
            end else begin
                PREADY  = 1'b1;
                PRDATA  = slave_rdata;
                PSLVERR = slave_err;
            end
        end else begin
            wcnt    = 0;
            PREADY  = 1'b1;
            PRDATA  = 32'hBAD0_BAD0;
            PSLVERR = 1'b1;
        end
    end

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic        pslverr;
        int          waits;
        logic [3:0]  exp_sel;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_pen;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int         lat;
        int         pen;
        logic [3:0] sel_seen;
        logic       addr_ok;
        @(negedge PCLK);
        chk($sformatf("v%0d req_ready_before", idx), 32'(req_ready), 32'd1);
        slave_waits = v.waits;
        slave_rdata = v.prdata;
        slave_err   = v.pslverr;
        req_valid   = 1'b1;
        req_write   = v.write;
        req_addr    = v.addr;
        req_wdata   = v.wdata;
        @(posedge PCLK);
        #1;
        req_valid = 1'b0;
        req_write = ~v.write;
        req_addr  = ~v.addr;
        req_wdata = ~v.wdata;
        lat = 1;
        pen = 0;
        sel_seen = 4'b0;
        addr_ok = 1'b1;
        while (!rsp_valid && lat < 64) begin
            if (PENABLE) pen++;
            if (PSELx != 4'b0) begin
                sel_seen = PSELx;
                if (PADDR !== v.addr) addr_ok = 1'b0;
            end
            @(posedge PCLK);
            #1;
            lat++;
        end
        chk($sformatf("v%0d rsp_valid", idx), 32'(rsp_valid), 32'd1);
        chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
        chk($sformatf("v%0d rsp_err", idx), 32'(rsp_err), 32'(v.exp_err));
        chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d psel", idx), 32'(sel_seen), 32'(v.exp_sel));
        chk($sformatf("v%0d penable_cycles", idx), 32'(pen), 32'(v.exp_pen));
        chk($sformatf("v%0d paddr_stable", idx), 32'(addr_ok), 32'd1);
        chk($sformatf("v%0d paddr_hold", idx), PADDR, v.addr);
        chk($sformatf("v%0d pwrite_hold", idx), 32'(PWRITE), 32'(v.write));
        chk($sformatf("v%0d pwdata_hold", idx), PWDATA, v.wdata);
        chk($sformatf("v%0d psel_drop", idx), 32'(PSELx), 32'd0);
        chk($sformatf("v%0d penable_drop", idx), 32'(PENABLE), 32'd0);
        chk($sformatf("v%0d req_ready_after", idx), 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        wr    addr           wdata          prdata         err   waits sel     eerr  erdata        lat pen
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 0,    4'b0001, 1'b0, 32'h0,         3,  1};
        vecs[1] = '{1'b0, 32'h0000_3004, 32'h0,         32'h1234_5678, 1'b0, 3,    4'b1000, 1'b0, 32'h1234_5678, 6,  4};
        vecs[2] = '{1'b0, 32'h0000_5000, 32'h0,         32'h7777_7777, 1'b0, 0,    4'b0000, 1'b1, 32'h0,         1,  0};
        vecs[3] = '{1'b0, 32'h0000_1008, 32'h0,         32'hFFFF_FFFF, 1'b1, 0,    4'b0010, 1'b1, 32'hFFFF_FFFF, 3,  1};
        vecs[4] = '{1'b1, 32'h0000_2FFC, 32'h0BAD_F00D, 32'h2222_2222, 1'b1, 2,    4'b0100, 1'b1, 32'h0,         5,  3};
        vecs[5] = '{1'b0, 32'h0000_4000, 32'h0,         32'h3333_3333, 1'b0, 0,    4'b0000, 1'b1, 32'h0,         1,  0};
        vecs[6] = '{1'b0, 32'h0000_0FFC, 32'h0,         32'hCAFE_F00D, 1'b0, 15,   4'b0001, 1'b0, 32'hCAFE_F00D, 18, 16};
        vecs[7] = '{1'b0, 32'h0000_3000, 32'h0,         32'h5555_5555, 1'b0, 1000, 4'b1000, 1'b1, 32'h0,         18, 16};
        vecs[8] = '{1'b1, 32'hFFFF_F000, 32'h0101_0101, 32'h4444_4444, 1'b0, 0,    4'b0000, 1'b1, 32'h0,         1,  0};
        vecs[9] = '{1'b0, 32'h0000_2010, 32'h0,         32'hA5A5_5A5A, 1'b0, 1,    4'b0100, 1'b0, 32'hA5A5_5A5A, 4,  2};

        repeat (2) @(posedge PCLK);
        #1;
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset PSELx", 32'(PSELx), 32'd0);
        chk("reset PENABLE", 32'(PENABLE), 32'd0);
        chk("reset PADDR", PADDR, 32'd0);
        chk("reset PWRITE", 32'(PWRITE), 32'd0);
        chk("reset PWDATA", PWDATA, 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i], i);
        end

        // Reset pulsed while the slave holds the bridge in ACCESS.
        @(negedge PCLK);
        slave_waits = 1000;
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_addr    = 32'h0000_2000;
        req_wdata   = 32'h1357_9BDF;
        @(posedge PCLK);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_mid penable_before", 32'(PENABLE), 32'd1);
        @(negedge PCLK);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("rst_mid PSELx", 32'(PSELx), 32'd0);
        chk("rst_mid PENABLE", 32'(PENABLE), 32'd0);
        chk("rst_mid PADDR", PADDR, 32'd0);
        chk("rst_mid PWRITE", 32'(PWRITE), 32'd0);
        chk("rst_mid PWDATA", PWDATA, 32'd0);
        chk("rst_mid req_ready", 32'(req_ready), 32'd1);
        chk("rst_mid rsp_valid", 32'(rsp_valid), 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(posedge PCLK);
            #1;
            chk($sformatf("rst_hold%0d rsp_valid", c), 32'(rsp_valid), 32'd0);
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge PCLK);
            #1;
            chk($sformatf("rst_rel%0d rsp_valid", c), 32'(rsp_valid), 32'd0);
        end
        run_txn(vecs[1], 10);
        run_txn(vecs[0], 11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
